telemetry_framer: RTL



---
 rtl/telemetry_pkg.sv | 42 ++++
 rtl/telemetry_framer_bin2bcd8.sv | 60 ++++++
 rtl/telemetry_framer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/telemetry_pkg.sv
// Shared constants, state encoding and helpers for the DHT11 telemetry framer.
// TELEMETRY_FRAMER_RAW_EN selects the frame length that includes the raw-byte prefix.
package telemetry_pkg;

  localparam logic [7:0] LPAREN = 8'h28;
  localparam logic [7:0] RPAREN = 8'h29;
  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] HASH   = 8'h23;
  localparam logic [7:0] ZERO   = 8'h30;

  localparam int unsigned FRAME_LEN_ASCII = 17;
  localparam int unsigned RAW_LEN         = 6;
  localparam int unsigned FRAME_LEN_RAW   = FRAME_LEN_ASCII + RAW_LEN;
`ifdef TELEMETRY_FRAMER_RAW_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_RAW;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_ASCII;
`endif

  localparam int unsigned NUM_FIELDS            = 4;
  localparam int unsigned BCD_STEPS             = 8;
  localparam int unsigned CONV_CYCLES_PER_FIELD = BCD_STEPS + 1;
  localparam int unsigned CONV_CYCLES           = NUM_FIELDS * CONV_CYCLES_PER_FIELD;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned FLD_W  = 2;
  localparam int unsigned BCD_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_CONV  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/telemetry_framer_bin2bcd8.sv
// Sequential 8-bit double-dabble converter: one load cycle, then eight shift-add-3 steps.
module bin2bcd8
  import telemetry_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] bin_i,
  output logic [3:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       done_o
);

  logic [19:0]       sh_q, sh_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  // Add 3 to every BCD nibble that is 5 or more, then shift the whole register left.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int k = 0; k < 3; k++) begin
      if (a[8+4*k +: 4] >= 4'd5) a[8+4*k +: 4] = a[8+4*k +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (load_i) begin
      sh_d  = {12'h000, bin_i};
      cnt_d = STEP_W'(BCD_STEPS);
    end else if (cnt_q != '0) begin
      sh_d   = dd_step(sh_q);
      cnt_d  = cnt_q - STEP_W'(1);
      done_d = (cnt_q == STEP_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign hund_o = sh_q[19:16];
  assign tens_o = sh_q[15:12];
  assign ones_o = sh_q[11:8];
  assign done_o = done_q;

endmodule

// File: rtl/telemetry_framer.sv
// Snapshots a DHT11 sample, converts it to "(TTT.tt)(HHH.hh)#" and streams it over valid/ready.
// Define TELEMETRY_FRAMER_RAW_EN to prepend "(" B3 B2 B1 B0 ")" with the unconverted bytes.
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int unsigned DEC_CLAMP = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] data_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [7:0] CLAMP_B = 8'(DEC_CLAMP);

  state_e                             state_q, state_d;
  logic [31:0]                        snap_q, snap_d;
  logic [STEP_W-1:0]                  step_q, step_d;
  logic [FLD_W-1:0]                   fld_q, fld_d;
  logic [FLD_W-1:0]                   cap_q, cap_d;
  logic [NUM_FIELDS-1:0][BCD_W-1:0]   dig_q, dig_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [7:0]                         tx_data_q, tx_data_d;
  logic                               tx_valid_q, tx_valid_d;
  logic                               busy_q, busy_d;
  logic                               frame_done_q, frame_done_d;

  logic       load_c;
  logic [7:0] bin_c;
  logic [3:0] hund_c, tens_c, ones_c;
  logic       bcd_done_c;

  function automatic logic [7:0] clamp_frac(input logic [7:0] v);
    return (v > CLAMP_B) ? CLAMP_B : v;
  endfunction

  // Digit fields: 0 T-int, 1 T-frac, 2 H-int, 3 H-frac; each {hund, tens, ones}.
  function automatic logic [7:0] ascii_byte(input logic [IDX_W-1:0] a,
                                            input logic [NUM_FIELDS-1:0][BCD_W-1:0] dig);
    logic [7:0] b;
    case (a)
      5'd0, 5'd8:  b = LPAREN;
      5'd1:        b = ascii_digit(dig[0][11:8]);
      5'd2:        b = ascii_digit(dig[0][7:4]);
      5'd3:        b = ascii_digit(dig[0][3:0]);
      5'd4, 5'd12: b = DOT;
      5'd5:        b = ascii_digit(dig[1][7:4]);
      5'd6:        b = ascii_digit(dig[1][3:0]);
      5'd7, 5'd15: b = RPAREN;
      5'd9:        b = ascii_digit(dig[2][11:8]);
      5'd10:       b = ascii_digit(dig[2][7:4]);
      5'd11:       b = ascii_digit(dig[2][3:0]);
      5'd13:       b = ascii_digit(dig[3][7:4]);
      5'd14:       b = ascii_digit(dig[3][3:0]);
      default:     b = HASH;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input logic [31:0] snap,
                                            input logic [NUM_FIELDS-1:0][BCD_W-1:0] dig);
    logic [7:0] b;
`ifdef TELEMETRY_FRAMER_RAW_EN
    if (idx < IDX_W'(RAW_LEN)) begin
      case (idx)
        5'd0:    b = LPAREN;
        5'd1:    b = snap[31:24];
        5'd2:    b = snap[23:16];
        5'd3:    b = snap[15:8];
        5'd4:    b = snap[7:0];
        default: b = RPAREN;
      endcase
    end else begin
      b = ascii_byte(idx - IDX_W'(RAW_LEN), dig);
    end
`else
    b = ascii_byte(idx, snap[7:0] == 8'h00 ? dig : dig);
`endif
    return b;
  endfunction

  // Field feed for the shared converter; fractional bytes are clamped before conversion.
  always_comb begin
    case (fld_q)
      2'd0:    bin_c = snap_q[15:8];
      2'd1:    bin_c = clamp_frac(snap_q[7:0]);
      2'd2:    bin_c = snap_q[31:24];
      default: bin_c = clamp_frac(snap_q[23:16]);
    endcase
  end

  assign load_c = (state_q == ST_CONV) && (step_q == '0);

  bin2bcd8 u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_c),
    .bin_i  (bin_c),
    .hund_o (hund_c),
    .tens_o (tens_c),
    .ones_o (ones_c),
    .done_o (bcd_done_c)
  );

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    step_d       = step_q;
    fld_d        = fld_q;
    cap_d        = cap_q;
    dig_d        = dig_q;
    idx_d        = idx_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    busy_d       = 1'b1;
    frame_done_d = 1'b0;

    // Converter results arrive one cycle after the last shift, during the next field's load.
    if (bcd_done_c) begin
      dig_d[cap_q] = {hund_c, tens_c, ones_c};
      cap_d        = cap_q + FLD_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        busy_d = start;
        if (start) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        snap_d  = data_valid;
        step_d  = '0;
        fld_d   = '0;
        cap_d   = '0;
        state_d = ST_CONV;
      end
      ST_CONV: begin
        if (step_q == STEP_W'(CONV_CYCLES_PER_FIELD - 1)) begin
          step_d = '0;
          fld_d  = fld_q + FLD_W'(1);
          if (fld_q == FLD_W'(NUM_FIELDS - 1)) begin
            state_d    = ST_SEND;
            idx_d      = '0;
            tx_valid_d = 1'b1;
            tx_data_d  = LPAREN;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_SEND: begin
        tx_valid_d = 1'b1;
        if (tx_ready) begin
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            state_d    = ST_DONE;
            tx_valid_d = 1'b0;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = frame_byte(idx_q + IDX_W'(1), snap_q, dig_q);
          end
        end
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      snap_q       <= '0;
      step_q       <= '0;
      fld_q        <= '0;
      cap_q        <= '0;
      dig_q        <= '0;
      idx_q        <= '0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      step_q       <= step_d;
      fld_q        <= fld_d;
      cap_q        <= cap_d;
      dig_q        <= dig_d;
      idx_q        <= idx_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
